// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and width defaults for the pipeline memory port arbiter
package pipeline_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {GNT_IF, GNT_D} grant_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and data ports with fair alternation
module mem_port_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall
);
    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    state_t state, state_n;
    grant_t gnt, last_grant, win;
    logic [CW-1:0] cnt;
    logic we_r, if_c, d_c, take, done;
    // In RESP the answered port still holds req, so only the other port may be granted
    always_comb begin
        if_c = if_req && (state == IDLE || (state == RESP && gnt == GNT_D));
        d_c = d_req && (state == IDLE || (state == RESP && gnt == GNT_IF));
        take = if_c || d_c;
        win = (if_c && d_c) ? (last_grant == GNT_IF ? GNT_D : GNT_IF) : (d_c ? GNT_D : GNT_IF);
        done = state == WAIT && cnt == '0;
        state_n = take ? ISSUE : state == ISSUE ? WAIT : done ? RESP : state == WAIT ? WAIT : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= GNT_IF;
            last_grant <= GNT_IF;
            cnt <= '0;
            we_r <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            if_ready <= 1'b0;
            if_rdata <= '0;
            d_ready <= 1'b0;
            d_rdata <= '0;
        end else begin
            state <= state_n;
            mem_en <= take;
            mem_we <= take && win == GNT_D && d_we;
            if (take) begin
                gnt <= win;
                last_grant <= win;
                we_r <= win == GNT_D && d_we;
                mem_addr <= win == GNT_D ? d_addr : if_addr;
                mem_wdata <= win == GNT_D ? d_wdata : '0;
            end
            cnt <= state == ISSUE ? CW'(MEM_LAT - 1) : (state == WAIT && cnt != '0) ? cnt - 1'b1 : cnt;
            if_ready <= done && gnt == GNT_IF;
            d_ready <= done && gnt == GNT_D;
            if (done && gnt == GNT_IF) if_rdata <= mem_rdata;
            if (done && gnt == GNT_D) d_rdata <= we_r ? '0 : mem_rdata;
        end
    end
    assign pipe_stall = (if_req && !if_ready) || (d_req && !d_ready);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus corner-case sequences for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam logic [31:0] G = 32'h5555_5555;
    typedef struct {
        logic ifr, dr, we;
        logic [31:0] ia, da, wd, mr;
        logic en, mwe;
        logic [31:0] ma, mwd;
        logic ir, drd;
        logic [31:0] ird, drdat;
        logic st;
    } vec_t;

    logic clk = 0, rst = 1;
    logic if_req = 0, d_req = 0, d_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic if_ready, d_ready, mem_en, mem_we, pipe_stall;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic if_ready1, d_ready1, mem_en1, mem_we1, pipe_stall1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    int checks = 0, errors = 0;
    vec_t vq[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata), .pipe_stall(pipe_stall1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ifr, input logic dr, input logic we, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] wd, input logic [31:0] mr);
        if_req = ifr; d_req = dr; d_we = we;
        if_addr = ia; d_addr = da; d_wdata = wd; mem_rdata = mr;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        next();
        next();
        rst = 0;
    endtask

    function automatic vec_t mk(logic ifr, logic dr, logic we, logic [31:0] ia, logic [31:0] da,
                                logic [31:0] wd, logic [31:0] mr, logic en, logic mwe,
                                logic [31:0] ma, logic [31:0] mwd, logic ir, logic drd,
                                logic [31:0] ird, logic [31:0] drdat, logic st);
        vec_t v;
        v.ifr = ifr; v.dr = dr; v.we = we; v.ia = ia; v.da = da; v.wd = wd; v.mr = mr;
        v.en = en; v.mwe = mwe; v.ma = ma; v.mwd = mwd;
        v.ir = ir; v.drd = drd; v.ird = ird; v.drdat = drdat; v.st = st;
        return v;
    endfunction

    initial begin
        // simultaneous load+fetch from reset: data wins, then fetch
        vq.push_back(mk(1, 1, 0, 'h20, 'h100, 0, G,            0, 0, 0, 0,      0, 0, 0, 0, 1));
        vq.push_back(mk(1, 1, 0, 'h20, 'h100, 0, G,            1, 0, 'h100, 0,  0, 0, 0, 0, 1));
        vq.push_back(mk(1, 1, 0, 'h20, 'h100, 0, G,            0, 0, 0, 0,      0, 0, 0, 0, 1));
        vq.push_back(mk(1, 1, 0, 'h20, 'h100, 0, 'hAAAA0001,   0, 0, 0, 0,      0, 0, 0, 0, 1));
        vq.push_back(mk(1, 1, 0, 'h20, 'h100, 0, G,            0, 0, 0, 0,      0, 1, 0, 'hAAAA0001, 1));
        vq.push_back(mk(1, 0, 0, 'h20, 'h100, 0, G,            1, 0, 'h20, 0,   0, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 'h20, 'h100, 0, G,            0, 0, 0, 0,      0, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 'h20, 'h100, 0, 'hBBBB0002,   0, 0, 0, 0,      0, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 'h20, 'h100, 0, G,            0, 0, 0, 0,      1, 0, 'hBBBB0002, 0, 0));
        vq.push_back(mk(0, 0, 0, 'h20, 'h100, 0, G,            0, 0, 0, 0,      0, 0, 0, 0, 0));
        // single fetch
        vq.push_back(mk(1, 0, 0, 'h10, 0, 0, G,                0, 0, 0, 0,      0, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 'h10, 0, 0, G,                1, 0, 'h10, 0,   0, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 'h10, 0, 0, G,                0, 0, 0, 0,      0, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 'h10, 0, 0, 'hDEADBEEF,       0, 0, 0, 0,      0, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 'h10, 0, 0, G,                0, 0, 0, 0,      1, 0, 'hDEADBEEF, 0, 0));
        vq.push_back(mk(0, 0, 0, 'h10, 0, 0, G,                0, 0, 0, 0,      0, 0, 0, 0, 0));
        // store: rdata reported as 0
        vq.push_back(mk(0, 1, 1, 0, 'h40, 'h12345678, G,       0, 0, 0, 0,      0, 0, 0, 0, 1));
        vq.push_back(mk(0, 1, 1, 0, 'h40, 'h12345678, G,       1, 1, 'h40, 'h12345678, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 1, 1, 0, 'h40, 'h12345678, G,       0, 0, 0, 0,      0, 0, 0, 0, 1));
        vq.push_back(mk(0, 1, 1, 0, 'h40, 'h12345678, G,       0, 0, 0, 0,      0, 0, 0, 0, 1));
        vq.push_back(mk(0, 1, 1, 0, 'h40, 'h12345678, G,       0, 0, 0, 0,      0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 'h40, 'h12345678, G,       0, 0, 0, 0,      0, 0, 0, 0, 0));

        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        next();
        @(negedge clk);
        chk("rst_if_ready", 0, 32'(if_ready), 0);
        chk("rst_if_rdata", 0, if_rdata, 0);
        chk("rst_d_ready", 0, 32'(d_ready), 0);
        chk("rst_d_rdata", 0, d_rdata, 0);
        chk("rst_mem_en", 0, 32'(mem_en), 0);
        chk("rst_mem_we", 0, 32'(mem_we), 0);
        chk("rst_mem_addr", 0, mem_addr, 0);
        chk("rst_mem_wdata", 0, mem_wdata, 0);
        chk("rst_pipe_stall", 0, 32'(pipe_stall), 0);
        chk("rst_mem_en_lat1", 0, 32'(mem_en1), 0);
        next();
        rst = 0;

        foreach (vq[i]) begin
            drive(vq[i].ifr, vq[i].dr, vq[i].we, vq[i].ia, vq[i].da, vq[i].wd, vq[i].mr);
            @(negedge clk);
            chk("vec_mem_en", i, 32'(mem_en), 32'(vq[i].en));
            chk("vec_mem_we", i, 32'(mem_we), 32'(vq[i].mwe));
            chk("vec_if_ready", i, 32'(if_ready), 32'(vq[i].ir));
            chk("vec_d_ready", i, 32'(d_ready), 32'(vq[i].drd));
            chk("vec_pipe_stall", i, 32'(pipe_stall), 32'(vq[i].st));
            if (vq[i].en) chk("vec_mem_addr", i, mem_addr, vq[i].ma);
            if (vq[i].mwe) chk("vec_mem_wdata", i, mem_wdata, vq[i].mwd);
            if (vq[i].ir) chk("vec_if_rdata", i, if_rdata, vq[i].ird);
            if (vq[i].drd) chk("vec_d_rdata", i, d_rdata, vq[i].drdat);
            next();
        end

        // fairness: both held continuously, grants alternate D, IF, D, IF
        do_reset();
        for (int c = 0; c < 18; c++) begin
            drive(1, 1, 0, 'h200, 'h300, 0, 32'(c));
            @(negedge clk);
            chk("fair_mem_en", c, 32'(mem_en), 32'(c % 4 == 1));
            if (c % 4 == 1) chk("fair_mem_addr", c, mem_addr, ((c / 4) % 2 == 0) ? 32'h300 : 32'h200);
            chk("fair_d_ready", c, 32'(d_ready), 32'(c % 8 == 4));
            chk("fair_if_ready", c, 32'(if_ready), 32'(c > 0 && c % 8 == 0));
            chk("fair_pipe_stall", c, 32'(pipe_stall), 1);
            next();
        end

        // reset mid-access aborts the fetch
        do_reset();
        drive(1, 0, 0, 'h30, 0, 0, G);
        next();
        next();
        rst = 1;
        if_req = 0;
        next();
        rst = 0;
        mem_rdata = 'hFEEDF00D;
        @(negedge clk);
        chk("abort_if_ready", 3, 32'(if_ready), 0);
        chk("abort_if_rdata", 3, if_rdata, 0);
        chk("abort_d_ready", 3, 32'(d_ready), 0);
        chk("abort_mem_en", 3, 32'(mem_en), 0);
        chk("abort_mem_we", 3, 32'(mem_we), 0);
        chk("abort_mem_addr", 3, mem_addr, 0);
        chk("abort_mem_wdata", 3, mem_wdata, 0);
        chk("abort_pipe_stall", 3, 32'(pipe_stall), 0);
        next();
        drive(1, 0, 0, 'h34, 0, 0, G);
        @(negedge clk);
        chk("abort_if_ready", 4, 32'(if_ready), 0);
        chk("abort_mem_en", 4, 32'(mem_en), 0);
        next();
        @(negedge clk);
        chk("abort_mem_en", 5, 32'(mem_en), 1);
        chk("abort_mem_addr", 5, mem_addr, 'h34);

        // MEM_LAT=1: mem_en cycle 1, d_ready cycle 3
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(0, c < 4, 0, 0, 'h80, 0, c == 2 ? 32'hCAFE0001 : G);
            @(negedge clk);
            chk("lat1_mem_en", c, 32'(mem_en1), 32'(c == 1));
            if (c == 1) chk("lat1_mem_addr", c, mem_addr1, 'h80);
            chk("lat1_d_ready", c, 32'(d_ready1), 32'(c == 3));
            if (c == 3) chk("lat1_d_rdata", c, d_rdata1, 'hCAFE0001);
            next();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
